// File: rtl/logic_gate_pkg.sv
// Shared op encoding for the logic gate pipeline.
package logic_gate_pkg;

    typedef enum logic [2:0] {
        OP_AND  = 3'b000,
        OP_OR   = 3'b001,
        OP_XOR  = 3'b010,
        OP_NAND = 3'b011,
        OP_NOR  = 3'b100,
        OP_XNOR = 3'b101,
        OP_MUX  = 3'b110,
        OP_ACC  = 3'b111
    } op_t;

endpackage

// File: rtl/gate_func.sv
// Combinational op decode and bitwise result compute.
// Latency: none (pure combinational). Backpressure: n/a.
// ACC: X is the updated accumulator (acc ^ a), which is also presented on acc_next.
module gate_func
    import logic_gate_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  op_t              op,
    input  logic [WIDTH-1:0] acc,
    output logic [WIDTH-1:0] x,
    output logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] z,
    output logic [WIDTH-1:0] acc_next
);

    always_comb begin
        x        = '0;
        y        = '0;
        z        = '0;
        acc_next = acc;
        case (op)
            OP_AND:  begin x = a & b;    y = b & c;    z = a & c;    end
            OP_OR:   begin x = a | b;    y = b | c;    z = a | c;    end
            OP_XOR:  begin x = a ^ b;    y = b ^ c;    z = a ^ c;    end
            OP_NAND: begin x = ~(a & b); y = ~(b & c); z = ~(a & c); end
            OP_NOR:  begin x = ~(a | b); y = ~(b | c); z = ~(a | c); end
            OP_XNOR: begin x = ~(a ^ b); y = ~(b ^ c); z = ~(a ^ c); end
            OP_MUX:  begin x = (c & a) | (~c & b); y = ~a; z = ~b; end
            OP_ACC:  begin
                acc_next = acc ^ a;
                x        = acc ^ a;
                y        = b;
                z        = c;
            end
            default: begin x = '0; y = '0; z = '0; end
        endcase
    end

endmodule

// File: rtl/logic_gate_pipe.sv
// Two-stage valid/ready bitwise logic pipeline (S1 operands, S2 results) with saturating accept counter.
// Latency: 2 cycles accept-to-out_valid; one transaction per cycle when out_ready stays high.
// Backpressure: out_ready=0 holds S2; in_ready drops once S1 and S2 are both full.
module logic_gate_pipe
    import logic_gate_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [WIDTH-1:0] C,
    input  logic [2:0]       op,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] X,
    output logic [WIDTH-1:0] Y,
    output logic [WIDTH-1:0] Z,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] cnt
);

    logic             s1_vld;
    logic [WIDTH-1:0] s1_a, s1_b, s1_c;
    op_t              s1_op;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] f_x, f_y, f_z, f_acc_next;
    logic             adv;
    logic             accept;

    assign adv      = s1_vld && (!out_valid || out_ready);
    assign in_ready = !s1_vld || adv;
    assign accept   = in_valid && in_ready;

    gate_func #(.WIDTH(WIDTH)) u_gate_func (
        .a        (s1_a),
        .b        (s1_b),
        .c        (s1_c),
        .op       (s1_op),
        .acc      (acc),
        .x        (f_x),
        .y        (f_y),
        .z        (f_z),
        .acc_next (f_acc_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld <= 1'b0;
            s1_a   <= '0;
            s1_b   <= '0;
            s1_c   <= '0;
            s1_op  <= OP_AND;
        end else if (accept) begin
            s1_vld <= 1'b1;
            s1_a   <= A;
            s1_b   <= B;
            s1_c   <= C;
            s1_op  <= op_t'(op);
        end else if (adv) begin
            s1_vld <= 1'b0;
        end
    end

    // acc advances as each ACC op leaves S1; strict ordering makes this
    // identical to updating at accept, and reset still drops in-flight work.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            X         <= '0;
            Y         <= '0;
            Z         <= '0;
            acc       <= '0;
        end else if (adv) begin
            out_valid <= 1'b1;
            X         <= f_x;
            Y         <= f_y;
            Z         <= f_z;
            acc       <= f_acc_next;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (accept && (cnt != {CNT_W{1'b1}})) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_logic_gate_pipe.sv
// Directed self-checking bench for logic_gate_pipe (main instance CNT_W=8, second CNT_W=2).
module tb_logic_gate_pipe;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] A, B, C;
    logic [2:0] op;
    logic       in_valid, out_ready;
    logic       in_ready, out_valid;
    logic [3:0] X, Y, Z;
    logic [7:0] cnt;
    logic       in_ready2, out_valid2;
    logic [3:0] X2, Y2, Z2;
    logic [1:0] cnt2;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    logic_gate_pipe #(.WIDTH(4), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .A(A), .B(B), .C(C), .op(op),
        .in_valid(in_valid), .in_ready(in_ready), .X(X), .Y(Y), .Z(Z),
        .out_valid(out_valid), .out_ready(out_ready), .cnt(cnt)
    );

    logic_gate_pipe #(.WIDTH(4), .CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .A(A), .B(B), .C(C), .op(op),
        .in_valid(in_valid), .in_ready(in_ready2), .X(X2), .Y(Y2), .Z(Z2),
        .out_valid(out_valid2), .out_ready(out_ready), .cnt(cnt2)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                         input logic [2:0] o);
        A = a; B = b; C = c; op = o; in_valid = 1'b1;
    endtask

    // single transaction with out_ready=1: accept, then result two edges later
    task automatic one_shot(input string tag, input logic [3:0] a, input logic [3:0] b,
                            input logic [3:0] c, input logic [2:0] o,
                            input logic [3:0] ex, input logic [3:0] ey, input logic [3:0] ez);
        drive(a, b, c, o);
        tick();
        in_valid = 1'b0;
        tick();
        check({tag, "_vld"}, {15'd0, out_valid}, 16'd1);
        check({tag, "_xyz"}, {4'd0, X, Y, Z}, {4'd0, ex, ey, ez});
        tick();
    endtask

    initial begin
        rst_n = 1'b0; A = '0; B = '0; C = '0; op = '0; in_valid = 1'b0; out_ready = 1'b1;
        #2;
        check("rst_out_valid", {15'd0, out_valid}, 16'd0);
        check("rst_xyz", {4'd0, X, Y, Z}, 16'd0);
        check("rst_cnt", {8'd0, cnt}, 16'd0);
        tick(); tick();
        rst_n = 1'b1;
        tick();
        check("post_rst_in_ready", {15'd0, in_ready}, 16'd1);

        // AND: result two cycles after accept
        drive(4'b1111, 4'b1010, 4'b0000, 3'b000);
        tick();
        in_valid = 1'b0;
        check("and_lat1_vld", {15'd0, out_valid}, 16'd0);
        check("cnt2_1", {14'd0, cnt2}, 16'd1);
        tick();
        check("and_vld", {15'd0, out_valid}, 16'd1);
        check("and_xyz", {4'd0, X, Y, Z}, {4'd0, 4'b1010, 4'b0000, 4'b0000});

        // OR then XOR back-to-back at full throughput
        drive(4'b1111, 4'b1010, 4'b0000, 3'b001);
        tick();
        check("cnt2_2", {14'd0, cnt2}, 16'd2);
        drive(4'b1111, 4'b1010, 4'b0000, 3'b010);
        check("tput_in_ready", {15'd0, in_ready}, 16'd1);
        tick();
        check("cnt2_3", {14'd0, cnt2}, 16'd3);
        in_valid = 1'b0;
        check("or_xyz", {3'd0, out_valid, X, Y, Z}, {3'd0, 1'b1, 4'b1111, 4'b1010, 4'b1111});
        tick();
        check("xor_xyz", {3'd0, out_valid, X, Y, Z}, {3'd0, 1'b1, 4'b0101, 4'b1010, 4'b1111});
        tick();
        check("drained", {15'd0, out_valid}, 16'd0);
        check("cnt_3", {8'd0, cnt}, 16'd3);

        // ACC: consecutive accepts from reset-cleared acc
        drive(4'b1011, 4'b0011, 4'b0101, 3'b111);
        tick();
        check("cnt2_sat_a", {14'd0, cnt2}, 16'd3);
        drive(4'b0101, 4'b0011, 4'b0101, 3'b111);
        tick();
        check("cnt2_sat_b", {14'd0, cnt2}, 16'd3);
        in_valid = 1'b0;
        check("acc1_xyz", {4'd0, X, Y, Z}, {4'd0, 4'b1011, 4'b0011, 4'b0101});
        tick();
        check("acc2_x", {12'd0, X}, 16'h000e);
        tick();
        one_shot("acc_hold", 4'b0000, 4'b1001, 4'b0110, 3'b111, 4'b1110, 4'b1001, 4'b0110);

        // remaining ops
        one_shot("nand", 4'b1100, 4'b1010, 4'b0001, 3'b011, 4'b0111, 4'b1111, 4'b1111);
        one_shot("nor",  4'b1100, 4'b1010, 4'b0001, 3'b100, 4'b0001, 4'b0100, 4'b0010);
        one_shot("xnor", 4'b1100, 4'b1010, 4'b0001, 3'b101, 4'b1001, 4'b0100, 4'b0010);
        one_shot("mux",  4'b1100, 4'b1010, 4'b1010, 3'b110, 4'b1000, 4'b0011, 4'b0101);
        check("cnt_10", {8'd0, cnt}, 16'd10);
        check("acc_untouched_by_others_x", {12'd0, X}, 16'h0008);

        // backpressure: three beats with out_ready=0
        out_ready = 1'b0;
        drive(4'b0001, 4'b0000, 4'b0000, 3'b010);
        check("bp_rdy1", {15'd0, in_ready}, 16'd1);
        tick();
        drive(4'b0010, 4'b0000, 4'b0000, 3'b010);
        check("bp_rdy2", {15'd0, in_ready}, 16'd1);
        tick();
        drive(4'b0011, 4'b0000, 4'b0000, 3'b010);
        check("bp_rdy3", {15'd0, in_ready}, 16'd0);
        check("bp_first", {3'd0, out_valid, X, Y, Z}, {3'd0, 1'b1, 4'b0001, 4'b0000, 4'b0001});
        tick();
        check("bp_hold_rdy", {15'd0, in_ready}, 16'd0);
        tick();
        check("bp_hold_x", {3'd0, out_valid, X, Y, Z}, {3'd0, 1'b1, 4'b0001, 4'b0000, 4'b0001});
        check("bp_cnt", {8'd0, cnt}, 16'd12);
        out_ready = 1'b1;
        #1;
        check("bp_release_rdy", {15'd0, in_ready}, 16'd1);
        tick();
        in_valid = 1'b0;
        check("bp_drain2", {3'd0, out_valid, X}, {11'd0, 1'b1, 4'b0010});
        tick();
        check("bp_drain3", {3'd0, out_valid, X}, {11'd0, 1'b1, 4'b0011});
        tick();
        check("bp_empty", {15'd0, out_valid}, 16'd0);
        check("bp_cnt13", {8'd0, cnt}, 16'd13);

        // reset with both stages full
        out_ready = 1'b0;
        drive(4'b0111, 4'b0000, 4'b0000, 3'b010);
        tick();
        drive(4'b1000, 4'b0000, 4'b0000, 3'b010);
        tick();
        in_valid = 1'b0;
        check("full_before_rst", {14'd0, out_valid, in_ready}, 16'b10);
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", {15'd0, out_valid}, 16'd0);
        check("arst_cnt", {8'd0, cnt}, 16'd0);
        check("arst_xyz", {4'd0, X, Y, Z}, 16'd0);
        tick();
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("no_stale", {15'd0, out_valid}, 16'd0);
        end
        one_shot("acc_after_rst", 4'b0110, 4'b0000, 4'b1111, 3'b111, 4'b0110, 4'b0000, 4'b1111);
        check("cnt_after_rst", {8'd0, cnt}, 16'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/logic_gate_pipe.md
LOGIC_GATE_PIPE -- requirements
Module: logic_gate_pipe

Interface
REQ-001 Parameter WIDTH, default 4: bit width of A, B, C, X, Y and Z.
REQ-002 Parameter CNT_W, default 8: width of the transaction counter.
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 A, B, C  in  WIDTH each  operand words.
REQ-006 op  in  3  operation select, sampled with the operands on accept.
REQ-007 in_valid  in  1  operands and op are valid.
REQ-008 in_ready  out  1  block can accept this cycle.
REQ-009 X, Y, Z  out  WIDTH each  result words.
REQ-010 out_valid  out  1  X, Y and Z hold a valid result.
REQ-011 out_ready  in  1  consumer accepts the result this cycle.
REQ-012 cnt  out  CNT_W  number of accepted transactions, saturating.

Function
REQ-013 Input handshake: a transaction is accepted when in_valid && in_ready on a rising edge.
REQ-014 Output handshake: a result is consumed when out_valid && out_ready on a rising edge.
REQ-015 Operation encoding: op 000..101 applies AND/OR/XOR/NAND/NOR/XNOR bitwise as X=f(A,B), Y=f(B,C), Z=f(A,C).
REQ-016 op 110 MUX: X = (C & A) | (~C & B); Y = ~A; Z = ~B.
REQ-017 op 111 ACC: on accept, acc <= acc ^ A; the result is X = acc ^ A (new value), Y = B, Z = C.
REQ-018 acc is a WIDTH-bit register changed only by ACC accepts and by reset.
REQ-019 Pipeline: two register stages, S1 (operands and op) and S2 (results driving X/Y/Z); latency from accept to out_valid is 2 cycles with no stall.
REQ-020 S2 loads from S1 when S1 is valid and (!out_valid || out_ready).
REQ-021 S1 loads on accept; in_ready = !s1_valid || S1-to-S2 transfer this cycle.
REQ-022 Full throughput: with out_ready held at 1, one transaction is accepted every cycle.
REQ-023 Backpressure: while out_ready=0, X/Y/Z/out_valid are held stable; once S1 and S2 are both full, in_ready=0.
REQ-024 Simultaneous consume and accept in one cycle: no bubble and no loss of data.
REQ-025 cnt increments by 1 on every accept and saturates at 2^CNT_W-1 with no wrap.
REQ-026 The result arithmetic is purely bitwise; no carries occur and widths are exactly WIDTH.

Reset
REQ-027 While rst_n=0: S1/S2 valid flags=0, out_valid=0, X=Y=Z=0, acc=0, cnt=0.
REQ-028 in_ready=1 from the first rising edge after rst_n deasserts.
REQ-029 Reset asserted mid-operation discards all in-flight transactions immediately, asynchronously.

Structure
REQ-030 A shared package logic_gate_pkg holds the op encoding constants (OP_AND..OP_ACC) and the 3-bit op typedef.
REQ-031 Sub-module gate_func holds the combinational op decode and result compute (A, B, C, op, acc -> X, Y, Z, acc_next); the pipeline registers and handshake live in logic_gate_pipe.

Verification
REQ-032 WIDTH=4, A=1111 B=1010 C=0000 op=AND, out_ready=1 -> after 2 cycles X=1010 Y=0000 Z=0000, out_valid=1.
REQ-033 Same operands with op=OR -> X=1111 Y=1010 Z=1111; with op=XOR -> X=0101 Y=1010 Z=1111.
REQ-034 ACC from reset: A=1011 then A=0101 on consecutive accepts -> X=1011, then X=1110; acc=1110.
REQ-035 out_ready=0, three back-to-back in_valid beats -> two accepted, in_ready=0 on the third, first result held stable; out_ready=1 -> results drain in order, then the third is accepted.
REQ-036 CNT_W=2, five accepts -> cnt reads 1, 2, 3, 3, 3.
REQ-037 rst_n pulsed low with both stages full -> out_valid=0, cnt=0 and acc=0 immediately; no stale result appears after release.
